// File: rtl/spike_event_encoder.sv
// spike_event_encoder: captures a neuron spike vector on spike_done and
// serialises its set bits, lowest index first, as address events with a
// programmable idle gap after each transfer. Counts spikes lost to overlap.
//
// Handshake: an event transfers on the rising clock edge where
// event_valid & event_ready are both 1; event_valid never falls and
// event_addr never changes until that transfer has happened.
module spike_event_encoder #(
  parameter int N_NEURONS  = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 17
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_NEURONS-1:0] spike,
  input  logic                 spike_done,
  input  logic                 event_ready,
  output logic                 event_valid,
  output logic [ADDR_W-1:0]    event_addr,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int         CNT_W    = $clog2(N_NEURONS + 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t                state, state_nxt;
  logic [N_NEURONS-1:0]  pending, pending_nxt;
  logic [N_NEURONS-1:0]  cleared, overlap;
  logic [7:0]            gap_cnt, gap_nxt;
  logic [7:0]            drop_nxt;
  logic [8:0]            drop_sum;
  logic                  valid_nxt;
  logic [ADDR_W-1:0]     addr_nxt;
  logic                  transfer;

  // Fixed priority encoder: lowest set index wins.
  function automatic logic [ADDR_W-1:0] lowest_index(input logic [N_NEURONS-1:0] v);
    lowest_index = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = ADDR_W'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N_NEURONS-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      popcount = popcount + CNT_W'(v[i]);
    end
  endfunction

  assign transfer = event_valid & event_ready;
  assign busy     = (|pending) | (state != ST_IDLE);

  // Pending mask update: clear the transferring bit first, then merge the new
  // capture, so a neuron re-spiking in its own transfer cycle is not a drop.
  always_comb begin
    cleared     = pending;
    overlap     = '0;
    pending_nxt = '0;
    if (transfer) cleared[event_addr] = 1'b0;
    pending_nxt = cleared;
    if (spike_done) begin
      pending_nxt = cleared | spike;
      overlap     = cleared & spike;
    end
    drop_sum = {1'b0, drop_cnt} + 9'(popcount(overlap));
    drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Next state and registered outputs of the event sequencer.
  always_comb begin
    state_nxt = state;
    valid_nxt = event_valid;
    addr_nxt  = event_addr;
    gap_nxt   = gap_cnt;
    case (state)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (|pending_nxt) begin
          state_nxt = ST_SEND;
          valid_nxt = 1'b1;
          addr_nxt  = lowest_index(pending_nxt);
        end
      end
      ST_SEND: begin
        valid_nxt = 1'b1;
        if (transfer) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = ST_GAP;
            valid_nxt = 1'b0;
            gap_nxt   = GAP_LOAD;
          end else if (|pending_nxt) begin
            addr_nxt = lowest_index(pending_nxt);
          end else begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      ST_GAP: begin
        valid_nxt = 1'b0;
        if (gap_cnt == 8'd0) begin
          if (|pending_nxt) begin
            state_nxt = ST_SEND;
            valid_nxt = 1'b1;
            addr_nxt  = lowest_index(pending_nxt);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
        addr_nxt  = '0;
        gap_nxt   = 8'd0;
      end
    endcase
  end

  // State, pending mask, gap counter and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      gap_cnt     <= 8'd0;
      event_valid <= 1'b0;
      event_addr  <= '0;
      drop_cnt    <= 8'd0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      gap_cnt     <= gap_nxt;
      event_valid <= valid_nxt;
      event_addr  <= addr_nxt;
      drop_cnt    <= drop_nxt;
    end
  end

endmodule
